// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the UART receive frame controller.
package rx_frame_pkg;

  // Frame parser states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DROP    = 3'd4
  } rx_state_e;

  // Reasons reported on err_code alongside err_pulse.
  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_LEN   = 3'd1;
  localparam logic [2:0] ERR_SPACE = 3'd2;
  localparam logic [2:0] ERR_CSUM  = 3'd3;
  localparam logic [2:0] ERR_TMO   = 3'd4;

  // Start-of-frame marker.
  localparam logic [7:0] SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/rx_frame_buf.sv
// Commit/rollback FIFO of {last, data} entries. Writes land at a speculative
// pointer; the reader only sees entries up to the commit pointer.
module rx_frame_buf #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [8:0]    push_data_i,
  input  logic          commit_i,
  input  logic          rollback_i,
  input  logic          pop_i,
  output logic [8:0]    head_o,
  output logic          valid_o,
  output logic [AW:0]   free_o
);

  localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_spec_q;
  logic [AW:0] commit_q;
  logic [AW:0] rd_q;

  // Show-ahead read of the committed head; free uses the pre-cycle read pointer.
  always_comb begin
    valid_o = (rd_q != commit_q);
    head_o  = mem_q[rd_q[AW-1:0]];
    free_o  = DEPTH_P - (wr_spec_q - rd_q);
  end

  // Storage array: speculative writes at wr_spec.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !rollback_i) begin
      mem_q[wr_spec_q[AW-1:0]] <= push_data_i;
    end
  end

  // Pointer updates: rollback wins over push; commit and pop are independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_spec_q <= '0;
      commit_q  <= '0;
      rd_q      <= '0;
    end else begin
      if (rollback_i)  wr_spec_q <= commit_q;
      else if (push_i) wr_spec_q <= wr_spec_q + 1'b1;
      if (commit_i)    commit_q  <= wr_spec_q;
      if (pop_i && valid_o) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART receive frame controller: parses SYNC, LEN, payload, CSUM frames and
// publishes payload downstream only after the XOR checksum matches.
// Handshake: a byte leaves the FIFO on a clock edge where out_valid and
// out_ready are both high; out_data/out_last are stable while out_valid is
// high and out_ready is low.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctrl_en,
  input  logic       rx_done_sig,
  input  logic [7:0] rx_data,
  output logic       rx_en_sig,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pkt_ok,
  output logic       err_pulse,
  output logic [2:0] err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  rx_state_e     state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    csum_q, csum_d;
  logic [8:0]    drop_q, drop_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          rx_en_q;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;

  logic          push, commit, rollback;
  logic [8:0]    push_data;
  logic [8:0]    head;
  logic [AW:0]   free;

  rx_frame_buf #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i(push_data),
    .commit_i   (commit),
    .rollback_i (rollback),
    .pop_i      (out_ready),
    .head_o     (head),
    .valid_o    (out_valid),
    .free_o     (free)
  );

  assign out_data  = head[7:0];
  assign out_last  = head[8];
  assign rx_en_sig = rx_en_q;
  assign pkt_ok    = ok_q;
  assign err_pulse = err_q;
  assign err_code  = code_q;

  // Next-state logic: abort beats an accepted byte, which beats timeout.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    csum_d    = csum_q;
    drop_d    = drop_q;
    idle_d    = (state_q == ST_IDLE) ? '0 : idle_q + 1'b1;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = ERR_NONE;
    push      = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    push_data = {(rem_q == 8'd1), rx_data};
    if (!ctrl_en) begin
      rollback = (state_q != ST_IDLE);
      state_d  = ST_IDLE;
      idle_d   = '0;
    end else if (rx_done_sig) begin
      idle_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (rx_data == 8'd0 || int'(rx_data) > MAX_LEN) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_IDLE;
          end else if (int'(rx_data) > int'(free)) begin
            err_d   = 1'b1;
            code_d  = ERR_SPACE;
            drop_d  = {1'b0, rx_data} + 9'd1;
            state_d = ST_DROP;
          end else begin
            rem_d   = rx_data;
            csum_d  = 8'h00;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          push   = 1'b1;
          rem_d  = rem_q - 8'd1;
          csum_d = csum_q ^ rx_data;
          if (rem_q == 8'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_data == csum_q) begin
            commit = 1'b1;
            ok_d   = 1'b1;
          end else begin
            rollback = 1'b1;
            err_d    = 1'b1;
            code_d   = ERR_CSUM;
          end
          state_d = ST_IDLE;
        end
        ST_DROP: begin
          drop_d = drop_q - 9'd1;
          if (drop_q == 9'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && idle_q == TMO_LAST) begin
      rollback = 1'b1;
      err_d    = 1'b1;
      code_d   = ERR_TMO;
      state_d  = ST_IDLE;
      idle_d   = '0;
    end
  end

  // State, counters and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      csum_q  <= '0;
      drop_q  <= '0;
      idle_q  <= '0;
      rx_en_q <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      drop_q  <= drop_d;
      idle_q  <= idle_d;
      rx_en_q <= ctrl_en;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl with a payload scoreboard.
module tb_rx_frame_ctrl;
  import rx_frame_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ctrl_en;
  logic       rx_done_sig;
  logic [7:0] rx_data;
  logic       rx_en_sig;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       pkt_ok;
  logic       err_pulse;
  logic [2:0] err_code;

  int errors = 0;
  int checks = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  logic [2:0] last_code = 3'd0;
  logic [8:0] exp_q[$];
  logic [7:0] tx_q[$];

  rx_frame_ctrl #(.DEPTH(16), .MAX_LEN(16), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .rx_done_sig(rx_done_sig),
    .rx_data(rx_data), .rx_en_sig(rx_en_sig), .out_data(out_data),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_ok(pkt_ok), .err_pulse(err_pulse), .err_code(err_code)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive queued bytes on consecutive cycles, then idle the strobe.
  task automatic send_q();
    while (tx_q.size() > 0) begin
      @(negedge clk);
      rx_data     = tx_q.pop_front();
      rx_done_sig = 1'b1;
    end
    @(negedge clk);
    rx_done_sig = 1'b0;
  endtask

  // Queue a well-formed frame and its expected payload.
  task automatic good_frame(input int len, input logic [7:0] base);
    logic [7:0] cs;
    cs = 8'h00;
    tx_q.push_back(SYNC_BYTE);
    tx_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      tx_q.push_back(base + 8'(i));
      cs ^= base + 8'(i);
      exp_q.push_back({(i == len - 1), base + 8'(i)});
    end
    tx_q.push_back(cs);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pulse counting and scoreboard pops.
  always @(negedge clk) begin
    if (pkt_ok) ok_cnt++;
    if (err_pulse) begin
      err_cnt++;
      last_code = err_code;
    end
    if (out_valid && out_ready) begin
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("pop_data", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
    end
  end

  initial begin : stim
    int ok0, err0;
    rst_n = 1'b0; ctrl_en = 1'b0; rx_done_sig = 1'b0; rx_data = 8'h00; out_ready = 1'b1;
    wait_cyc(3);
    chk("rst_rx_en", 32'(rx_en_sig), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'({out_last, out_data}), 32'd0);
    chk("rst_pulses", 32'({pkt_ok, err_pulse, err_code}), 32'd0);
    rst_n = 1'b1;
    wait_cyc(1);
    ctrl_en = 1'b1;
    #1 chk("rx_en_lag", 32'(rx_en_sig), 32'd0);
    wait_cyc(1);
    chk("rx_en_on", 32'(rx_en_sig), 32'd1);

    // Good frame AA 02 11 22 33.
    ok0 = ok_cnt; err0 = err_cnt;
    good_frame(2, 8'h11);
    send_q(); wait_cyc(6);
    chk("good_ok", 32'(ok_cnt - ok0), 32'd1);
    chk("good_err", 32'(err_cnt - err0), 32'd0);
    chk("good_drained", 32'(exp_q.size()), 32'd0);
    chk("good_valid_off", 32'(out_valid), 32'd0);

    // Checksum failure: AA 02 11 22 00.
    ok0 = ok_cnt; err0 = err_cnt;
    tx_q = '{8'hAA, 8'h02, 8'h11, 8'h22, 8'h00};
    send_q(); wait_cyc(2);
    chk("csum_err", 32'(err_cnt - err0), 32'd1);
    chk("csum_code", 32'(last_code), 32'(ERR_CSUM));
    chk("csum_ok", 32'(ok_cnt - ok0), 32'd0);
    chk("csum_valid", 32'(out_valid), 32'd0);
    chk("csum_free", 32'(dut.u_buf.free_o), 32'd16);

    // Bad lengths and a stray byte.
    err0 = err_cnt;
    tx_q = '{8'hAA, 8'h00};
    send_q(); wait_cyc(1);
    chk("len0_err", 32'(err_cnt - err0), 32'd1);
    chk("len0_code", 32'(last_code), 32'(ERR_LEN));
    tx_q = '{8'hAA, 8'h11};
    send_q(); wait_cyc(1);
    chk("len17_err", 32'(err_cnt - err0), 32'd2);
    chk("len17_code", 32'(last_code), 32'(ERR_LEN));
    ok0 = ok_cnt;
    tx_q = '{8'h55};
    send_q(); wait_cyc(2);
    chk("stray_pulses", 32'((err_cnt - err0) + (ok_cnt - ok0)), 32'd2);
    chk("stray_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // No space: 10 committed, 8 refused, 9 bytes dropped, 4 fits.
    out_ready = 1'b0;
    ok0 = ok_cnt; err0 = err_cnt;
    good_frame(10, 8'h01);
    tx_q.push_back(SYNC_BYTE); tx_q.push_back(8'h08);
    repeat (9) tx_q.push_back(8'hAA);
    good_frame(4, 8'h21);
    send_q(); wait_cyc(2);
    chk("space_err", 32'(err_cnt - err0), 32'd1);
    chk("space_code", 32'(last_code), 32'(ERR_SPACE));
    chk("space_ok", 32'(ok_cnt - ok0), 32'd2);
    chk("space_head", 32'({out_valid, out_last, out_data}), 32'h201);
    out_ready = 1'b1;
    wait_cyc(20);
    chk("space_drained", 32'(exp_q.size()), 32'd0);
    ok0 = ok_cnt;
    good_frame(8, 8'h40);
    send_q(); wait_cyc(12);
    chk("space_retry_ok", 32'(ok_cnt - ok0), 32'd1);
    chk("space_retry_drained", 32'(exp_q.size()), 32'd0);

    // Timeout mid-payload, then recovery.
    ok0 = ok_cnt; err0 = err_cnt;
    tx_q = '{8'hAA, 8'h03, 8'h11};
    send_q(); wait_cyc(10);
    chk("tmo_not_early", 32'(err_cnt - err0), 32'd0);
    for (int i = 0; i < 40 && err_cnt == err0; i++) @(negedge clk);
    chk("tmo_err", 32'(err_cnt - err0), 32'd1);
    chk("tmo_code", 32'(last_code), 32'(ERR_TMO));
    chk("tmo_valid", 32'(out_valid), 32'd0);
    tx_q = '{8'hAA, 8'h01, 8'h5A, 8'h5A};
    exp_q.push_back({1'b1, 8'h5A});
    send_q(); wait_cyc(3);
    chk("tmo_next_ok", 32'(ok_cnt - ok0), 32'd1);

    // ctrl_en drop mid-payload: silent rollback, bytes ignored while off.
    ok0 = ok_cnt; err0 = err_cnt;
    tx_q = '{8'hAA, 8'h04, 8'h01, 8'h02};
    send_q();
    ctrl_en = 1'b0;
    wait_cyc(1);
    chk("abort_rx_en", 32'(rx_en_sig), 32'd0);
    tx_q = '{8'hAA};
    send_q();
    ctrl_en = 1'b1;
    wait_cyc(2);
    chk("abort_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("abort_pulses", 32'((err_cnt - err0) + (ok_cnt - ok0)), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    tx_q = '{8'hAA, 8'h01, 8'h77, 8'h77};
    exp_q.push_back({1'b1, 8'h77});
    send_q(); wait_cyc(3);
    chk("abort_next_ok", 32'(ok_cnt - ok0), 32'd1);

    // Asynchronous reset mid-frame.
    tx_q = '{8'hAA, 8'h03, 8'h01};
    send_q();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", 32'({rx_en_sig, out_valid, out_last, out_data}), 32'd0);
    chk("arst_pulses", 32'({pkt_ok, err_pulse, err_code}), 32'd0);
    chk("arst_idle", 32'(dut.state_q), 32'(ST_IDLE));
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
    chk("arst_no_stale", 32'(out_valid), 32'd0);
    ok0 = ok_cnt;
    tx_q = '{8'hAA, 8'h01, 8'h42, 8'h42};
    exp_q.push_back({1'b1, 8'h42});
    send_q(); wait_cyc(4);
    chk("arst_next_ok", 32'(ok_cnt - ok0), 32'd1);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
Controller for the UART receive datapath. It gates the receiver with rx_en_sig, consumes bytes on rx_done_sig, and parses frames of the form SYNC(0xAA), LEN, LEN payload bytes, CSUM. Payload is written speculatively into a commit-capable FIFO and becomes visible downstream only after the checksum passes. Sits between the UART RX core and the command/data consumer.

Parameters:
DEPTH, 16, payload FIFO entries; power of 2, >= MAX_LEN.
MAX_LEN, 16, largest legal LEN value.
TIMEOUT_CYC, 50000, max idle clk cycles between bytes inside a frame.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
ctrl_en  input  1  enable; low holds receiver off and aborts any frame
rx_done_sig  input  1  one-cycle pulse: rx_data holds a valid byte
rx_data  input  8  received byte
rx_en_sig  output  1  receiver enable to UART RX core
out_data  output  8  payload byte at FIFO head
out_last  output  1  head byte is the last byte of its frame
out_valid  output  1  committed byte available
out_ready  input  1  consumer accepts byte when out_valid && out_ready
pkt_ok  output  1  one-cycle pulse: frame committed
err_pulse  output  1  one-cycle pulse: frame dropped
err_code  output  3  reason, valid with err_pulse: 1 bad LEN, 2 no space, 3 checksum, 4 timeout

Behaviour:
- Reset values: rx_en_sig 0, out_valid 0, out_data 0, out_last 0, pkt_ok 0, err_pulse 0, err_code 0. State IDLE, all pointers and counters 0.
- rx_en_sig is registered: equals ctrl_en delayed by one cycle.
- Bytes are ignored while ctrl_en is 0.
- FSM states: IDLE, LEN, PAYLOAD, CSUM, DROP. All transitions occur on an accepted byte (rx_done_sig && ctrl_en), except timeout and abort.
- IDLE: byte 0xAA goes to LEN. Any other byte is discarded silently.
- LEN:
  - LEN == 0 or LEN > MAX_LEN: err_code 1, go to IDLE.
  - LEN > free entries (free = DEPTH - (wr_spec - rd_ptr)): err_code 2, load drop counter with LEN+1, go to DROP.
  - Otherwise: load remaining = LEN, clear csum, go to PAYLOAD.
- PAYLOAD:
  - Each byte is written at wr_spec with last = (remaining == 1). Then wr_spec++, remaining--, csum ^= byte.
  - Go to CSUM after the last byte.
- CSUM:
  - Byte == csum: commit_ptr <= wr_spec, pkt_ok pulse.
  - Byte != csum: wr_spec <= commit_ptr (rollback), err_code 3.
  - Go to IDLE in both cases.
- DROP: discard bytes until the drop counter reaches 0, then go to IDLE.
- err_pulse and pkt_ok are registered and fire the cycle after the deciding byte.
- Timeout:
  - Idle counter counts in LEN, PAYLOAD, CSUM and DROP; it resets on every accepted byte.
  - Reaching TIMEOUT_CYC-1: rollback wr_spec, err_code 4, go to IDLE.
- ctrl_en falling mid-frame: rollback, go to IDLE, no error pulse.
- Output FIFO:
  - Show-ahead: out_valid = (rd_ptr != commit_ptr). out_data and out_last are read combinationally from mem[rd_ptr].
  - Pop advances rd_ptr.
  - Uncommitted bytes are never visible.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- A pop and a push in the same cycle are both honoured. free is computed from the pre-cycle rd_ptr (conservative).
- A commit and a pop in the same cycle are both honoured.
- Bytes arriving back-to-back on consecutive cycles must be handled.

Decomposition:
- Package rx_frame_pkg: state enum (IDLE, LEN, PAYLOAD, CSUM, DROP), err_code constants (ERR_NONE=0, ERR_LEN=1, ERR_SPACE=2, ERR_CSUM=3, ERR_TMO=4), SYNC_BYTE=8'hAA.
- Sub-module rx_frame_buf: 9-bit wide commit/rollback FIFO (wr_spec, commit_ptr, rd_ptr, free count).
- rx_frame_ctrl keeps the FSM, checksum, timeout and drop counters.

Test Plan:
- Reset and ctrl_en=1 -> rx_en_sig 1 one cycle later. Send AA 02 11 22 33 -> pkt_ok pulse, then out_data 11 (last 0) and 22 (last 1) with out_ready=1, then out_valid 0.
- Send AA 02 11 22 00 -> err_pulse with err_code 3, out_valid never asserts, free space restored to 16.
- Send AA 00 -> err_code 1. Send AA 11 (17 > MAX_LEN) -> err_code 1. Send 55 -> no pulse, state stays IDLE.
- out_ready=0, commit AA 0A + 10 bytes + csum, then AA 08 + ... -> err_code 2. The following 9 bytes are dropped and a subsequent good frame commits once space is available.
- TIMEOUT_CYC=20: send AA 03 11, then idle 20 cycles -> err_code 4, next AA 01 5A 5A commits with pkt_ok.
- Drop ctrl_en mid-payload, then assert rst_n low mid-frame -> rollback with no pulse, then all outputs return to reset values; no stale data after either.
